// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register behind the shifter.
// The next frame starts on the same edge the previous stop bit ends, so back-to-back frames have no idle gap.
module uart_tx #(
    parameter logic [23:0] BAUD_CNT_MAX = 24'd5207
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_nxt;
    logic        r_hold_valid;
    logic        w_hold_valid_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [23:0] r_baud_cnt;
    logic [23:0] w_baud_cnt_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_done;
    logic        w_done_nxt;

    logic        w_accept;
    logic        w_bit_end;
    logic        w_load;

    assign w_accept  = in_valid && !r_hold_valid;
    assign w_bit_end = (r_baud_cnt == BAUD_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_shift      <= w_shift_nxt;
            r_baud_cnt   <= w_baud_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_tx_nxt         = r_tx;
        w_done_nxt       = 1'b0;
        w_load           = 1'b0;
        w_baud_cnt_nxt   = (r_state == IDLE || w_bit_end) ? '0 : r_baud_cnt + 24'd1;

        case (r_state)
            IDLE: begin
                w_load = r_hold_valid;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_done_nxt = 1'b1;
                    if (r_hold_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Transfer needs a full hold and acceptance needs an empty one, so these never overlap.
        if (w_load) begin
            w_state_nxt      = START;
            w_shift_nxt      = r_hold;
            w_hold_valid_nxt = 1'b0;
            w_baud_cnt_nxt   = '0;
            w_tx_nxt         = 1'b0;
        end
        if (w_accept) begin
            w_hold_nxt       = in_data;
            w_hold_valid_nxt = 1'b1;
        end
    end

    assign in_ready = !r_hold_valid;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != IDLE);
    assign tx_done  = r_done;

endmodule
